// File: rtl/mem_access_sequencer.sv
// Memory-stage sequencer: alignment check, ldd/std beat splitting, req/ack bus handshake and
// load writeback. Define MEM_TIMEOUT_EN to abort a beat that waits TIMEOUT_CYCLES for bus_ack.
module mem_access_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_access_size,
    input  logic        mem_access_signed,
    input  logic [31:0] addr,
    input  logic [63:0] store_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam logic [1:0] SzByte   = 2'b00;
    localparam logic [1:0] SzHalf   = 2'b01;
    localparam logic [1:0] SzWord   = 2'b10;
    localparam logic [1:0] SzDouble = 2'b11;

    localparam logic [1:0] FcIllegal = 2'b01;
    localparam logic [1:0] FcBus     = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StAcc0,
        StAcc1,
        StWbHi,
        StWbLo,
        StFin
    } state_t;

    state_t      state_q;
    logic        op_read_q;
    logic [1:0]  op_size_q;
    logic        op_signed_q;
    logic [4:0]  op_rd_q;
    logic [1:0]  op_off_q;
    // Holds the std low word until beat 1, then the ldd beat data awaiting writeback.
    logic [31:0] hold_q;

`ifdef MEM_TIMEOUT_EN
    localparam logic [1:0]  FcTimeout = 2'b11;
    localparam int unsigned TmoW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    logic [TmoW-1:0] tmo_q;
`endif

    logic        misaligned;
    logic [3:0]  start_be;
    logic [31:0] start_wdata;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_ext;

    assign busy = (state_q != StIdle);

    always_comb begin
        misaligned  = 1'b0;
        start_be    = 4'hF;
        start_wdata = store_data[31:0];
        unique case (mem_access_size)
            SzByte: begin
                start_be    = 4'b1000 >> addr[1:0];
                start_wdata = {4{store_data[7:0]}};
            end
            SzHalf: begin
                misaligned  = addr[0];
                start_be    = addr[1] ? 4'b0011 : 4'b1100;
                start_wdata = {2{store_data[15:0]}};
            end
            SzWord: begin
                misaligned  = |addr[1:0];
            end
            default: begin
                misaligned  = (|addr[2:0]) | rd[0];
                start_wdata = store_data[63:32];
            end
        endcase
    end

    // Big-endian lane select: offset 0 is bus_rdata[31:24].
    always_comb begin
        rbyte    = bus_rdata[31:24];
        unique case (op_off_q)
            2'd0: rbyte = bus_rdata[31:24];
            2'd1: rbyte = bus_rdata[23:16];
            2'd2: rbyte = bus_rdata[15:8];
            default: rbyte = bus_rdata[7:0];
        endcase
        rhalf    = op_off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        load_ext = bus_rdata;
        unique case (op_size_q)
            SzByte:  load_ext = {{24{op_signed_q & rbyte[7]}}, rbyte};
            SzHalf:  load_ext = {{16{op_signed_q & rhalf[15]}}, rhalf};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_read_q   <= 1'b0;
            op_size_q   <= 2'b00;
            op_signed_q <= 1'b0;
            op_rd_q     <= 5'd0;
            op_off_q    <= 2'b00;
            hold_q      <= 32'd0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_be      <= 4'd0;
            bus_wdata   <= 32'd0;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'd0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
`ifdef MEM_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            wb_valid   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && (mem_read || mem_write)) begin
                        op_read_q   <= mem_read;
                        op_size_q   <= mem_access_size;
                        op_signed_q <= mem_access_signed;
                        op_rd_q     <= rd;
                        op_off_q    <= addr[1:0];
                        hold_q      <= store_data[31:0];
                        if ((mem_read && mem_write) || misaligned) begin
                            state_q    <= StFin;
                            done       <= 1'b1;
                            fault      <= 1'b1;
                            fault_code <= FcIllegal;
                        end else begin
                            state_q   <= StAcc0;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= start_be;
                            bus_wdata <= start_wdata;
`ifdef MEM_TIMEOUT_EN
                            tmo_q     <= '0;
`endif
                        end
                    end
                end
                StAcc0, StAcc1: begin
                    if (bus_ack) begin
                        if (bus_err) begin
                            state_q    <= StFin;
                            bus_req    <= 1'b0;
                            done       <= 1'b1;
                            fault      <= 1'b1;
                            fault_code <= FcBus;
                        end else if (state_q == StAcc0 && op_size_q == SzDouble) begin
                            // bus_req stays high straight into the second beat.
                            state_q   <= StAcc1;
                            bus_addr  <= bus_addr + 32'd4;
                            bus_wdata <= hold_q;
                            hold_q    <= bus_rdata;
`ifdef MEM_TIMEOUT_EN
                            tmo_q     <= '0;
`endif
                        end else if (state_q == StAcc0) begin
                            state_q  <= StFin;
                            bus_req  <= 1'b0;
                            done     <= 1'b1;
                            wb_valid <= op_read_q;
                            wb_rd    <= op_rd_q;
                            wb_data  <= load_ext;
                        end else begin
                            bus_req <= 1'b0;
                            if (op_read_q) begin
                                state_q  <= StWbHi;
                                wb_valid <= 1'b1;
                                wb_rd    <= op_rd_q;
                                wb_data  <= hold_q;
                                hold_q   <= bus_rdata;
                            end else begin
                                state_q <= StFin;
                                done    <= 1'b1;
                            end
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_q == TmoLast) begin
                        state_q    <= StFin;
                        bus_req    <= 1'b0;
                        done       <= 1'b1;
                        fault      <= 1'b1;
                        fault_code <= FcTimeout;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
`endif
                end
                StWbHi: begin
                    state_q  <= StWbLo;
                    wb_valid <= 1'b1;
                    wb_rd    <= {op_rd_q[4:1], 1'b1};
                    wb_data  <= hold_q;
                    done     <= 1'b1;
                end
                StWbLo, StFin: state_q <= StIdle;
                default:       state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized bench for mem_access_sequencer: a transaction-level model predicts bus beats,
// writebacks, fault codes and start-to-done latency; a per-cycle monitor compares the DUT.
module tb_mem_access_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_access_size = 2'b00;
    logic        mem_access_signed = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [63:0] store_data = 64'd0;
    logic [4:0]  rd = 5'd0;
    logic        busy, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done, fault;
    logic [1:0]  fault_code;

    always #5 clk = ~clk;

    mem_access_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read), .mem_write(mem_write),
        .mem_access_size(mem_access_size), .mem_access_signed(mem_access_signed), .addr(addr),
        .store_data(store_data), .rd(rd), .busy(busy), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_err(bus_err), .bus_rdata(bus_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .done(done), .fault(fault), .fault_code(fault_code)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          delay;
    } beat_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    beat_t beat_q[$];
    wb_t   wb_q[$];
    logic [1:0]  exp_code = 2'b00;
    bit          pending = 1'b0;
    bit          exp_timeout = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          req_cycles = 0;
    int          wait_cnt = 0;
    logic [31:0] last_addr = 0, last_wdata = 0, last_wb_data = 0;
    logic [3:0]  last_be = 0;
    logic [4:0]  last_wb_rd = 0;
    logic [1:0]  last_code = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Big-endian load value: bytes off..off+n-1 of the word, then optional sign extension.
    function automatic logic [31:0] load_val(logic [31:0] w, int off, int n, bit sg);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < n; k++) v = (v << 8) | ((w >> (8 * (3 - (off + k)))) & 32'hFF);
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Fills the expectation queues; returns the expected start-to-done latency (0 = ignored).
    function automatic int build(bit rdf, bit wrf, logic [1:0] sz, bit sg, logic [31:0] a,
                                 logic [63:0] sd, logic [4:0] r, logic [31:0] rd0,
                                 logic [31:0] rd1, bit e0, bit e1, int d0, int d1);
        int n, align, off, nb;
        beat_t bt;
        wb_t w;
        logic [31:0] src;
        exp_timeout = 1'b0;
        if (!rdf && !wrf) return 0;
        n = (sz == 2'b11) ? 4 : (1 << sz);
        align = (sz == 2'b11) ? 8 : n;
        off = int'(a[1:0]);
        if ((rdf && wrf) || (a % align != 0) || (sz == 2'b11 && r % 2 != 0)) begin
            exp_code = 2'b01;
            return 2;
        end
        nb = (sz == 2'b11) ? 2 : 1;
        for (int b = 0; b < nb; b++) begin
            bt.we = wrf;
            bt.addr = (a & ~32'd3) + 32'(4 * b);
            src = (sz == 2'b11 && b == 0) ? sd[63:32] : sd[31:0];
            for (int i = 0; i < 4; i++) begin
                bt.be[3-i] = (i >= off && i < off + n);
                bt.wdata[31-8*i -: 8] = src[8*((n-1) - (i % n)) +: 8];
            end
            bt.rdata = (b == 0) ? rd0 : rd1;
            bt.err = (b == 0) ? e0 : e1;
            bt.delay = (b == 0) ? d0 : d1;
            if (b == 0 || !e0) beat_q.push_back(bt);
        end
        if (e0 || (nb == 2 && e1)) begin
            exp_code = 2'b10;
            return (e0 || nb == 1) ? 3 + d0 : 4 + d0 + d1;
        end
        exp_code = 2'b00;
        if (rdf) begin
            if (nb == 1) begin
                w.rd = r; w.data = load_val(rd0, off, n, sg); wb_q.push_back(w);
            end else begin
                w.rd = r; w.data = rd0; wb_q.push_back(w);
                w.rd = r | 5'd1; w.data = rd1; wb_q.push_back(w);
            end
        end
        if (nb == 1) return 3 + d0;
        return rdf ? 5 + d0 + d1 : 4 + d0 + d1;
    endfunction

    task automatic drive(bit rdf, bit wrf, logic [1:0] sz, bit sg, logic [31:0] a,
                         logic [63:0] sd, logic [4:0] r);
        start = 1'b1; mem_read = rdf; mem_write = wrf; mem_access_size = sz;
        mem_access_signed = sg; addr = a; store_data = sd; rd = r;
    endtask

    task automatic wait_done(int exp_lat);
        int cyc = 0;
        bit got = 1'b0;
        while (cyc < 300 && !got) begin
            @(posedge clk); cyc++;
            @(negedge clk); start = 1'b0;
            if (done) got = 1'b1;
        end
        if (!got) check("done_seen", 0, 1);
        else check("latency", cyc + 1, exp_lat);
        @(negedge clk);
    endtask

    task automatic run_op(bit rdf, bit wrf, logic [1:0] sz, bit sg, logic [31:0] a,
                          logic [63:0] sd, logic [4:0] r, logic [31:0] rd0, logic [31:0] rd1,
                          bit e0, bit e1, int d0, int d1);
        int lat;
        lat = build(rdf, wrf, sz, sg, a, sd, r, rd0, rd1, e0, e1, d0, d1);
        req_cycles = 0;
        drive(rdf, wrf, sz, sg, a, sd, r);
        if (lat == 0) begin
            @(negedge clk); start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("ignored_busy", busy, 0);
            end
        end else begin
            pending = 1'b1;
            wait_done(lat);
        end
    endtask

    // Bus responder: acks each beat after its scheduled number of wait cycles.
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n || !bus_req || beat_q.size() == 0) begin
            wait_cnt = 0;
            bus_ack = 1'b0; bus_err = 1'b0;
        end else if (wait_cnt >= beat_q[0].delay) begin
            bus_ack = 1'b1; bus_err = beat_q[0].err; bus_rdata = beat_q[0].rdata;
            wait_cnt = 0;
        end else begin
            bus_ack = 1'b0; bus_err = 1'($urandom); bus_rdata = $urandom;
            wait_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_req) begin
                req_cycles++;
                if (beat_q.size() == 0) check("bus_req_unexpected", 1, 0);
                else begin
                    check("bus_we", bus_we, beat_q[0].we);
                    check("bus_addr", bus_addr, beat_q[0].addr);
                    check("bus_be", bus_be, beat_q[0].be);
                    if (beat_q[0].we) check("bus_wdata", bus_wdata, beat_q[0].wdata);
                    last_addr = bus_addr; last_wdata = bus_wdata; last_be = bus_be;
                    if (bus_ack) beat_q.delete(0);
                end
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) check("wb_unexpected", 1, 0);
                else begin
                    check("wb_rd", wb_rd, wb_q[0].rd);
                    check("wb_data", wb_data, wb_q[0].data);
                    last_wb_rd = wb_rd; last_wb_data = wb_data;
                    wb_q.delete(0);
                end
            end
            if (done) begin
                if (!pending) check("done_unexpected", 1, 0);
                else begin
                    check("fault", fault, exp_code != 2'b00);
                    check("fault_code", fault_code, exp_code);
                    if (exp_timeout) beat_q.delete();
                    check("beats_left", beat_q.size(), 0);
                    check("wb_left", wb_q.size(), 0);
                    last_code = fault_code;
                    pending = 1'b0;
                end
            end else if (fault) check("fault_without_done", 1, 0);
        end
    end

    always @(posedge clk) begin
        if (rst_n && start && busy) begin
            failures++;
            $display("FAIL start_while_busy at %0t", $time);
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_bus"}, {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, 0);
        check({tag, "_wb"}, {wb_valid, wb_rd, wb_data}, 0);
        check({tag, "_done"}, {done, fault, fault_code}, 0);
    endtask

    initial begin
        bit rdf, wrf, sg, e0, e1;
        logic [1:0] sz;
        logic [31:0] a;
        logic [4:0] r;
        int sel, lat;

        #12;
        check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // ldub
        run_op(1, 0, 2'b00, 0, 32'h1003, 64'd0, 5'd5, 32'hAABBCCDD, 0, 0, 0, 0, 0);
        check("ldub_be", last_be, 4'b0001);
        check("ldub_wb_rd", last_wb_rd, 5'd5);
        check("ldub_wb_data", last_wb_data, 32'h000000DD);
        // ldsh with delayed ack
        run_op(1, 0, 2'b01, 1, 32'h2000, 64'd0, 5'd3, 32'h8001FFFF, 0, 0, 0, 2, 0);
        check("ldsh_req_cycles", req_cycles, 3);
        check("ldsh_wb_data", last_wb_data, 32'hFFFF8001);
        // std
        run_op(0, 1, 2'b11, 0, 32'h3000, 64'h1122334455667788, 5'd2, 0, 0, 0, 0, 0, 0);
        check("std_last_addr", last_addr, 32'h3004);
        check("std_last_wdata", last_wdata, 32'h55667788);
        check("std_be", last_be, 4'hF);
        // ldd
        run_op(1, 0, 2'b11, 0, 32'h4000, 64'd0, 5'd6, 32'hDEADBEEF, 32'h01234567, 0, 0, 0, 0);
        check("ldd_wb_rd", last_wb_rd, 5'd7);
        check("ldd_wb_data", last_wb_data, 32'h01234567);
        // misaligned ld, odd-rd ldd
        run_op(1, 0, 2'b10, 0, 32'h1002, 64'd0, 5'd1, 0, 0, 0, 0, 0, 0);
        check("misal_code", last_code, 2'b01);
        check("misal_req", req_cycles, 0);
        run_op(1, 0, 2'b11, 0, 32'h5000, 64'd0, 5'd7, 0, 0, 0, 0, 0, 0);
        check("oddrd_code", last_code, 2'b01);
        check("oddrd_req", req_cycles, 0);
        // ldd with bus error on beat1
        run_op(1, 0, 2'b11, 0, 32'h6000, 64'd0, 5'd8, 32'h1, 32'h2, 0, 1, 1, 0);
        check("err1_code", last_code, 2'b10);

        // Reset during ACC0
        lat = build(1, 0, 2'b11, 0, 32'h7000, 64'd0, 5'd10, 0, 0, 0, 0, 100, 0);
        pending = 1'b1;
        drive(1, 0, 2'b11, 0, 32'h7000, 64'd0, 5'd10);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("pre_reset_req", bus_req, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        beat_q.delete(); wb_q.delete(); pending = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", busy, 0);

`ifdef MEM_TIMEOUT_EN
        lat = build(1, 0, 2'b10, 0, 32'h8000, 64'd0, 5'd4, 0, 0, 0, 0, 100000, 0);
        wb_q.delete();
        exp_code = 2'b11; exp_timeout = 1'b1; pending = 1'b1; req_cycles = 0;
        drive(1, 0, 2'b10, 0, 32'h8000, 64'd0, 5'd4);
        wait_done(2 + TO);
        check("timeout_req_cycles", req_cycles, TO);
        check("timeout_code", last_code, 2'b11);
`endif

        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 19);
            rdf = (sel == 1) || (sel >= 2 && sel <= 11);
            wrf = (sel == 1) || (sel >= 12);
            sz = 2'($urandom);
            sg = 1'($urandom);
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a = a & ~32'd7;
            r = 5'($urandom);
            if (sz == 2'b11 && $urandom_range(0, 4) != 0) r[0] = 1'b0;
            e0 = ($urandom_range(0, 11) == 0);
            e1 = ($urandom_range(0, 11) == 0);
            run_op(rdf, wrf, sz, sg, a, {$urandom, $urandom}, r, $urandom, $urandom, e0, e1,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
